// File: rtl/core_pkg.sv
// Shared widths and the write-request record used across the register-file write side.
package core_pkg;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of pending load-return writes; caller gates push on !full and pop on !empty.
module wb_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Entry storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU results and queued load returns onto the single register-file write port,
// and tracks outstanding loads per register.
module reg_writeback #(
  parameter int DATA_W    = core_pkg::DATA_W,
  parameter int IDX_W     = core_pkg::IDX_W,
  parameter int MEM_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_wb_valid,
  input  logic [IDX_W-1:0]           alu_wb_idx,
  input  logic [DATA_W-1:0]          alu_wb_data,
  input  logic                       mem_issue,
  input  logic [IDX_W-1:0]           mem_issue_idx,
  input  logic                       mem_wb_valid,
  output logic                       mem_wb_ready,
  input  logic [IDX_W-1:0]           mem_wb_idx,
  input  logic [DATA_W-1:0]          mem_wb_data,
  output logic                       reg_we,
  output logic [IDX_W-1:0]           reg_waddr,
  output logic [DATA_W-1:0]          reg_wdata,
  output logic [2**IDX_W-1:0]        busy,
  output logic [$clog2(MEM_DEPTH):0] mem_pending,
  output logic                       waw_err
);
  import core_pkg::*;

  localparam int NREG = 2**IDX_W;

  wb_req_t           push_req;
  wb_req_t           head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              alu_sel;
  logic              head_write;
  logic              issue_valid;
  logic              waw_hit;
  logic [NREG-1:0]   busy_next;

  assign push_req     = '{idx: mem_wb_idx, data: mem_wb_data};
  assign mem_wb_ready = !rst && !fifo_full;
  assign push         = mem_wb_valid && mem_wb_ready;

  // ALU wins the port; a head entry for r0 is still consumed, just not written.
  assign alu_sel     = alu_wb_valid && (alu_wb_idx != {IDX_W{1'b0}});
  assign pop         = !alu_sel && !fifo_empty;
  assign head_write  = pop && (head.idx != {IDX_W{1'b0}});
  assign issue_valid = mem_issue && (mem_issue_idx != {IDX_W{1'b0}});

  wb_fifo #(.DEPTH(MEM_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .count     (mem_pending),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scoreboard update (a new issue overrides a same-cycle clear) and hazard detection.
  always_comb begin
    busy_next = busy;
    if (head_write) begin
      busy_next[head.idx] = 1'b0;
    end else begin
      busy_next = busy;
    end
    if (issue_valid) begin
      busy_next[mem_issue_idx] = 1'b1;
    end else begin
      busy_next[0] = busy_next[0];
    end
    waw_hit = (alu_sel && busy[alu_wb_idx]) || (issue_valid && busy[mem_issue_idx]);
  end

  // Registered write port, scoreboard and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we    <= 1'b0;
      reg_waddr <= {IDX_W{1'b0}};
      reg_wdata <= {DATA_W{1'b0}};
      busy      <= {NREG{1'b0}};
      waw_err   <= 1'b0;
    end else begin
      reg_we <= alu_sel || head_write;
      if (alu_sel) begin
        reg_waddr <= alu_wb_idx;
        reg_wdata <= alu_wb_data;
      end else if (head_write) begin
        reg_waddr <= head.idx;
        reg_wdata <= head.data;
      end else begin
        reg_waddr <= reg_waddr;
        reg_wdata <= reg_wdata;
      end
      busy    <= busy_next;
      waw_err <= waw_err || waw_hit;
    end
  end

endmodule
